// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU result-mux scheduler.
// Holds the scheduler state encoding, the requester count, the mux select
// encodings and a one-hot to index helper.
package alu_sched_pkg;

    localparam int NREQ = 4;

    // Maximum number of back-to-back grants a locked source may hold.
    localparam logic [2:0] LOCK_MAX = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        HOLD    = 2'd2,
        CAPTURE = 2'd3
    } sched_state_t;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    // Convert a one-hot grant vector into the mux select index.
    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] onehot);
        logic [1:0] idx;
        case (onehot)
            4'b0001: idx = SEL_A;
            4'b0010: idx = SEL_B;
            4'b0100: idx = SEL_C;
            4'b1000: idx = SEL_D;
            default: idx = SEL_A;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter.
// The request at index ptr has highest priority, then ptr+1, ... wrapping 3->0.
module rr_arb4
    import alu_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      win_idx,
    output logic            win_vld
);

    logic [NREQ-1:0] rot_s;
    logic [1:0]      off_s;

    // Rotate requests so the pointer position sits at bit 0, then pick the lowest set bit.
    always_comb begin
        rot_s = 4'({req, req} >> ptr);
        if (rot_s[0]) begin
            off_s = 2'd0;
        end else if (rot_s[1]) begin
            off_s = 2'd1;
        end else if (rot_s[2]) begin
            off_s = 2'd2;
        end else if (rot_s[3]) begin
            off_s = 2'd3;
        end else begin
            off_s = 2'd0;
        end
        win_idx = ptr + off_s;
        win_vld = |req;
    end

endmodule

// File: rtl/alu_mux_sched.sv
// Round-robin scheduler for the shared 16-bit 4:1 ALU result mux.
// A winner's select is driven for one SETUP cycle, frozen for HOLD_CYCLES
// cycles while the adiabatic pipeline settles, then flagged capturable for
// one CAPTURE cycle.
// Optional feature: define ALU_MUX_SCHED_LOCK_EN to add the lock input, which
// lets a source keep the mux for up to LOCK_MAX consecutive grants.
module alu_mux_sched
    import alu_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
)
(
    input  logic            clkpos,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
`ifdef ALU_MUX_SCHED_LOCK_EN
    input  logic [NREQ-1:0] lock,
`endif
    output logic [NREQ-1:0] gnt,
    output logic            in0,
    output logic            in1,
    output logic            mux_en,
    output logic            res_valid,
    output logic [1:0]      res_id,
    output logic            busy
);

    sched_state_t    state_r, state_s;
    logic [3:0]      cnt_r, cnt_s;
    logic [1:0]      ptr_r, ptr_s;
    logic [NREQ-1:0] gnt_r, gnt_s;
    logic [1:0]      sel_r, sel_s;
    logic            active_r, active_s;
    logic            res_valid_r, res_valid_s;
    logic [1:0]      res_id_r, res_id_s;
`ifdef ALU_MUX_SCHED_LOCK_EN
    logic [2:0]      lock_cnt_r, lock_cnt_s;
`endif

    logic [1:0]      cur_s;
    logic [NREQ-1:0] arb_req_s;
    logic [1:0]      win_idx_s;
    logic            win_vld_s;
    logic            grant_s;
    logic            release_s;

    // Current winner follows the held grant; the winner is excluded from re-arbitration.
    always_comb begin
        cur_s     = onehot_to_idx(gnt_r);
        arb_req_s = req & ~gnt_r;
    end

    rr_arb4 u_arb (
        .req     (arb_req_s),
        .ptr     (ptr_r),
        .win_idx (win_idx_s),
        .win_vld (win_vld_s)
    );

    // Next-state and next-output computation for the grant sequence.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        ptr_s       = ptr_r;
        gnt_s       = gnt_r;
        sel_s       = sel_r;
        res_valid_s = 1'b0;
        res_id_s    = res_id_r;
        grant_s     = 1'b0;
        release_s   = 1'b0;
`ifdef ALU_MUX_SCHED_LOCK_EN
        lock_cnt_s  = lock_cnt_r;
`endif

        case (state_r)
            IDLE: begin
                if (win_vld_s) begin
                    grant_s = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
            end
            SETUP: begin
                if (!req[cur_s]) begin
                    release_s = 1'b1;
                end else begin
                    state_s = HOLD;
                    cnt_s   = 4'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (!req[cur_s]) begin
                    release_s = 1'b1;
                end else if (cnt_r == 4'd0) begin
                    state_s     = CAPTURE;
                    res_valid_s = 1'b1;
                    res_id_s    = cur_s;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            CAPTURE: begin
`ifdef ALU_MUX_SCHED_LOCK_EN
                // A locked winner is re-granted in place: same select, pointer untouched.
                if (lock[cur_s] && req[cur_s] && (lock_cnt_r < LOCK_MAX)) begin
                    state_s    = SETUP;
                    lock_cnt_s = lock_cnt_r + 3'd1;
                end else if (win_vld_s) begin
                    grant_s = 1'b1;
                end else begin
                    release_s = 1'b1;
                end
`else
                if (win_vld_s) begin
                    grant_s = 1'b1;
                end else begin
                    release_s = 1'b1;
                end
`endif
            end
            default: begin
                release_s = 1'b1;
            end
        endcase

        if (grant_s) begin
            state_s = SETUP;
            gnt_s   = 4'b0001 << win_idx_s;
            sel_s   = win_idx_s;
            ptr_s   = win_idx_s + 2'd1;
`ifdef ALU_MUX_SCHED_LOCK_EN
            lock_cnt_s = 3'd1;
`endif
        end else if (release_s) begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
            sel_s   = 2'b00;
        end else begin
            state_s = state_s;
        end

        active_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clkpos) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            ptr_r       <= 2'd0;
            gnt_r       <= 4'b0000;
            sel_r       <= 2'b00;
            active_r    <= 1'b0;
            res_valid_r <= 1'b0;
            res_id_r    <= 2'd0;
`ifdef ALU_MUX_SCHED_LOCK_EN
            lock_cnt_r  <= 3'd0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            ptr_r       <= ptr_s;
            gnt_r       <= gnt_s;
            sel_r       <= sel_s;
            active_r    <= active_s;
            res_valid_r <= res_valid_s;
            res_id_r    <= res_id_s;
`ifdef ALU_MUX_SCHED_LOCK_EN
            lock_cnt_r  <= lock_cnt_s;
`endif
        end
    end

    assign gnt       = gnt_r;
    assign in0       = sel_r[0];
    assign in1       = sel_r[1];
    assign mux_en    = active_r;
    assign busy      = active_r;
    assign res_valid = res_valid_r;
    assign res_id    = res_id_r;

endmodule

// File: tb/tb_alu_mux_sched.sv
// Self-checking bench for alu_mux_sched.
// A transaction-level model (grant period = SETUP + HOLD + CAPTURE cycles)
// predicts every output each cycle; extra instances cover HOLD_CYCLES 1 and 15.
// Define ALU_MUX_SCHED_LOCK_EN to also exercise the lock input.
module tb_alu_mux_sched;

    localparam int H = 4;

    logic       clkpos = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] req    = 4'b0000;
    logic [3:0] lock   = 4'b0000;
    logic [3:0] req_h1  = 4'b0000;
    logic [3:0] req_h15 = 4'b0000;

    logic [3:0] gnt;    logic in0, in1, mux_en, res_valid, busy;   logic [1:0] res_id;
    logic [3:0] gnt1;   logic a0, a1, men1, rv1, bz1;              logic [1:0] id1;
    logic [3:0] gnt15;  logic b0, b1, men15, rv15, bz15;           logic [1:0] id15;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model state: a grant occupies phases 0 (SETUP), 1..H (HOLD), H+1 (CAPTURE).
    bit m_busy;
    bit m_resv;
    int m_win, m_phase, m_ptr, m_resid, m_lockcnt;

    always #5 clkpos = ~clkpos;

    alu_mux_sched #(.HOLD_CYCLES(H)) u_dut (
        .clkpos(clkpos), .rst(rst), .req(req),
`ifdef ALU_MUX_SCHED_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .in0(in0), .in1(in1), .mux_en(mux_en),
        .res_valid(res_valid), .res_id(res_id), .busy(busy)
    );

    alu_mux_sched #(.HOLD_CYCLES(1)) u_h1 (
        .clkpos(clkpos), .rst(rst), .req(req_h1),
`ifdef ALU_MUX_SCHED_LOCK_EN
        .lock(4'b0000),
`endif
        .gnt(gnt1), .in0(a0), .in1(a1), .mux_en(men1),
        .res_valid(rv1), .res_id(id1), .busy(bz1)
    );

    alu_mux_sched #(.HOLD_CYCLES(15)) u_h15 (
        .clkpos(clkpos), .rst(rst), .req(req_h15),
`ifdef ALU_MUX_SCHED_LOCK_EN
        .lock(4'b0000),
`endif
        .gnt(gnt15), .in0(b0), .in1(b1), .mux_en(men15),
        .res_valid(rv15), .res_id(id15), .busy(bz15)
    );

    wire [10:0] dut_vec = {gnt, in1, in0, mux_en, res_valid, res_id, busy};
    wire [10:0] h1_vec  = {gnt1, a1, a0, men1, rv1, id1, bz1};
    wire [10:0] h15_vec = {gnt15, b1, b0, men15, rv15, id15, bz15};

    // Pack an output vector: busy implies grant/select of winner w.
    function automatic logic [10:0] mk(input bit b, input int w, input bit rv, input int id);
        logic [3:0] g;
        logic [1:0] s;
        g = b ? 4'(1 << w) : 4'b0000;
        s = b ? 2'(w) : 2'b00;
        return {g, s, b, rv, 2'(id), b};
    endfunction

    function automatic logic [10:0] exp_vec();
        return mk(m_busy, m_win, m_resv, m_resid);
    endfunction

    // Round robin: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic start_grant(input int w);
        m_busy = 1'b1; m_win = w; m_phase = 0; m_ptr = (w + 1) % 4; m_lockcnt = 1;
    endtask

    // Advance the model across one clock edge using the inputs applied this cycle.
    task automatic model_step();
        int w;
        if (rst) begin
            m_busy = 0; m_resv = 0; m_win = 0; m_phase = 0; m_ptr = 0; m_resid = 0; m_lockcnt = 0;
            return;
        end
        m_resv = 0;
        if (!m_busy) begin
            w = pick(req);
            if (w >= 0) start_grant(w);
        end else if (m_phase <= H) begin
            if (!req[m_win]) begin
                m_busy = 0;
            end else begin
                m_phase++;
                if (m_phase == H + 1) begin
                    m_resv = 1; m_resid = m_win;
                end
            end
        end else begin
            if (lock[m_win] && req[m_win] && m_lockcnt < 4) begin
                m_phase = 0; m_lockcnt++;
            end else begin
                w = pick(req & ~(4'b0001 << m_win));
                if (w >= 0) start_grant(w);
                else m_busy = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clkpos);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; lock = 4'b0000;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (dut_vec !== 11'd0) begin
            fails++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 11'd0);
        end
        req = 4'b0010;
        tick(); tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (dut_vec !== 11'd0) begin
                fails++; $display("FAIL reset_mid_hold got=%h exp=%h", dut_vec, 11'd0);
            end
        end
        rst = 1'b0; req = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (res_valid !== 1'b0 || dut_vec !== exp_vec()) begin
                fails++; $display("FAIL reset_no_result got=%h exp=%h", dut_vec, exp_vec());
            end
        end
        req = 4'b0001;
        tick();
        tests++;
        if (gnt !== 4'b0001 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL reset_regrant gnt=%b exp=0001", gnt);
        end
    endtask

    task automatic test_single();
        logic [10:0] want;
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 7) req = 4'b0000;
            want = mk(c <= 6, 2, c == 6, (c >= 6) ? 2 : 0);
            tests++;
            if (dut_vec !== want || dut_vec !== exp_vec()) begin
                fails++; $display("FAIL single c=%0d got=%h exp=%h", c, dut_vec, want);
            end
        end
    endtask

    task automatic test_all_requesting();
        int ids[$];
        int when[$];
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (res_valid) begin ids.push_back(int'(res_id)); when.push_back(c); end
            tests++;
            if (dut_vec !== exp_vec() || busy !== 1'b1) begin
                fails++; $display("FAIL all_req c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        tests++;
        if (ids.size() !== 5) begin
            fails++; $display("FAIL all_req_count got=%0d exp=5", ids.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (ids[i] !== order[i]) begin
                    fails++; $display("FAIL all_req_order i=%0d got=%0d exp=%0d", i, ids[i], order[i]);
                end
                if (i > 0 && (when[i] - when[i-1]) !== H + 2) begin
                    fails++; $display("FAIL all_req_spacing i=%0d got=%0d exp=%0d", i, when[i] - when[i-1], H + 2);
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0010;
        tick(); tick(); tick();
        req = 4'b0000;
        tick();
        tests++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL abort_idle got=%h exp=%h", dut_vec, exp_vec());
        end
        req = 4'b1111;
        tick();
        tests++;
        if (gnt !== 4'b0100 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL abort_next_gnt got=%b exp=0100", gnt);
        end
        req = 4'b0000;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_select_sweep();
        logic [10:0] w1, w15;
        do_reset();
        req_h1 = 4'b1000; req_h15 = 4'b1000;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1 + 3) req_h1 = 4'b0000;
            if (c == 15 + 3) req_h15 = 4'b0000;
            w1  = mk(c <= 1 + 2, 3, c == 1 + 2, (c >= 1 + 2) ? 3 : 0);
            w15 = mk(c <= 15 + 2, 3, c == 15 + 2, (c >= 15 + 2) ? 3 : 0);
            tests++;
            if (h1_vec !== w1) begin
                fails++; $display("FAIL sweep_h1 c=%0d got=%h exp=%h", c, h1_vec, w1);
            end
            tests++;
            if (h15_vec !== w15) begin
                fails++; $display("FAIL sweep_h15 c=%0d got=%h exp=%h", c, h15_vec, w15);
            end
        end
    endtask

    task automatic test_random();
        int drop_id = -1;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (drop_id >= 0) req[drop_id] = 1'b0;
            if (m_busy && m_phase <= H && $urandom_range(39) == 0) req[m_win] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && i != drop_id && $urandom_range(3) == 0) req[i] = 1'b1;
            end
            drop_id = m_resv ? m_resid : -1;
        end
        req = 4'b0000;
    endtask

`ifdef ALU_MUX_SCHED_LOCK_EN
    task automatic test_lock();
        int ids[$];
        int order[6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        lock = 4'b0001; req = 4'b0011;
        for (int c = 1; c <= 38; c++) begin
            tick();
            if (res_valid) ids.push_back(int'(res_id));
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL lock c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (i >= ids.size() || ids[i] !== order[i]) begin
                fails++; $display("FAIL lock_order i=%0d got=%0d exp=%0d", i, (i < ids.size()) ? ids[i] : -1, order[i]);
            end
        end
        lock = 4'b0000; req = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_abort();
        test_select_sweep();
        test_random();
`ifdef ALU_MUX_SCHED_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mux_sched.md
Name: alu_mux_sched

Overview:
- Round-robin scheduler that shares the 16-bit 4:1 ALU result mux between four requesters (sources a, b, c, d).
- Drives the mux select pair (in0/in1) and holds it stable for the full adiabatic pipeline depth before signalling the result as capturable.
- Sits between the ALU operation issue logic and the result mux in the ALU datapath.

Parameters:
- HOLD_CYCLES, 4, cycles spent in HOLD with the select frozen (adiabatic phase pipeline depth); legal range 1..15.
- NREQ, 4, number of requesters; fixed at 4 (matches the mux inputs), not overridable.

Ports:
- clkpos  in  1  single system clock, rising-edge active.
- rst  in  1  synchronous, active-high reset.
- req  in  4  request per source; bit i = source i (0=a, 1=b, 2=c, 3=d).
- gnt  out  4  one-hot grant; all zero when idle.
- in0  out  1  mux select LSB.
- in1  out  1  mux select MSB; {in1,in0} = index of the granted source.
- mux_en  out  1  high while the select is valid (SETUP, HOLD, CAPTURE).
- res_valid  out  1  one-cycle pulse: mux output is settled and capturable.
- res_id  out  2  index of the source whose result is flagged by res_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Single clock clkpos; reset is synchronous and active-high on rst.
- Reset (rst=1 at a clkpos edge): state=IDLE; gnt=0; in0=in1=0; mux_en=0; res_valid=0; res_id=0; busy=0; RR pointer=0 (source 0 has highest priority). Reset mid-operation aborts immediately: no res_valid is produced.
- States:
  - IDLE: if any req bit is set, pick a winner and go to SETUP.
  - SETUP: exactly 1 cycle; gnt, in0/in1 and mux_en are driven. Then go to HOLD with counter=HOLD_CYCLES-1.
  - HOLD: exactly HOLD_CYCLES cycles; the counter decrements each cycle; leave when counter==0.
  - CAPTURE: exactly 1 cycle; res_valid=1, res_id=winner, select still held. Then:
    - any req bit set (the winner's req is ignored during CAPTURE) -> arbitrate and go to SETUP;
    - otherwise -> IDLE.
- Arbitration: round robin starting at the index after the last winner, wrapping 3->0. The pointer updates on entry to SETUP.
- Registered outputs: all outputs are registered. gnt, in0/in1 and mux_en change only on SETUP entry or on return to IDLE.
- Latency: req rises and is sampled at edge N.
  - SETUP during cycle N+1.
  - HOLD during cycles N+2 .. N+1+HOLD_CYCLES.
  - res_valid during cycle N+2+HOLD_CYCLES.
- Requester contract: hold req high until res_valid with its res_id, then drop req in the following cycle.
- Abort: if the granted source drops req during SETUP or HOLD, go to IDLE next cycle with no res_valid. The pointer still advances past it.
- Simultaneous requests: exactly one grant; the others wait. No source waits more than 3 grant periods.
- Counter width: 4 bits.

Optional Feature:
- ALU_MUX_SCHED_LOCK_EN defined: adds input lock (4 bits). If lock[winner] is high in CAPTURE and req[winner] is high, the same source is re-granted: go to SETUP with an unchanged winner and no pointer advance.
  - Max 4 consecutive locked grants; the 5th forces normal round robin.
  - Lock counter resets on rst and on any grant change.
- Undefined: no lock port; pure round robin.

Decomposition:
- Package alu_sched_pkg holds:
  - state enum sched_state_t {IDLE, SETUP, HOLD, CAPTURE};
  - localparam NREQ=4;
  - select encoding constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11;
  - function onehot_to_idx.
- Sub-module rr_arb4: combinational. Inputs req[3:0] and ptr[1:0]; outputs win_idx[1:0] and win_vld.

Test Plan:
- Reset: assert rst for 2 cycles mid-HOLD -> all outputs 0 next cycle; no res_valid; next req=0001 is granted source 0.
- Single request: req=0100 at edge 0, HOLD_CYCLES=4 -> gnt=0100 and {in1,in0}=10 from cycle 1; res_valid=1 with res_id=2 exactly at cycle 6; IDLE at cycle 7 after req drops.
- All requesting: req=1111 held -> grant order 0,1,2,3,0. CAPTURE goes directly to SETUP with no IDLE gap. res_valid spacing is 6 cycles.
- Abort: source 1 drops req in the 2nd HOLD cycle -> IDLE next cycle, no res_valid; next req=1111 grants source 2.
- Select stability: assert in0/in1 unchanged from SETUP through CAPTURE, and mux_en matches. Sweep HOLD_CYCLES=1 and 15.
- LOCK_EN: lock=0001, req=0011 held -> source 0 granted 4 times, then source 1, then source 0 again.
